// File: rtl/alu_pkg.sv
// Shared widths, funct3 encodings and alu_ext constants for the ALU execution unit.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned EXT_W  = 3;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU    = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR     = 3'b100;
  localparam logic [F3_W-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [F3_W-1:0] F3_OR      = 3'b110;
  localparam logic [F3_W-1:0] F3_AND     = 3'b111;

  // alu_ext[0] selects SUB for ADD and SRA for SRL; the full code 3'b010 selects LUI.
  localparam int unsigned       EXT_SUB_SRA_BIT = 0;
  localparam logic [EXT_W-1:0]  EXT_LUI         = 3'b010;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational integer datapath: RV32I register/immediate ALU ops plus LUI pass-through.
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [F3_W-1:0]   funct3_i,
  input  logic [EXT_W-1:0]  alu_ext_i,
  output logic [DATA_W-1:0] result_o
);

  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  sra_res;
  logic               alt_op;

  assign shamt   = op2_i[SHAMT_W-1:0];
  assign alt_op  = alu_ext_i[EXT_SUB_SRA_BIT];
  assign sra_res = $signed(op1_i) >>> shamt;

  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_ADD_SUB: result_o = alt_op ? (op1_i - op2_i) : (op1_i + op2_i);
      F3_SLL:     result_o = op1_i << shamt;
      F3_SLT:     result_o = ($signed(op1_i) < $signed(op2_i)) ? DATA_W'(1) : '0;
      F3_SLTU:    result_o = (op1_i < op2_i) ? DATA_W'(1) : '0;
      F3_XOR:     result_o = op1_i ^ op2_i;
      F3_SRL_SRA: result_o = alt_op ? sra_res : (op1_i >> shamt);
      F3_OR:      result_o = op1_i | op2_i;
      F3_AND:     result_o = op1_i & op2_i;
      default:    result_o = '0;
    endcase
    // LUI overrides funct3; any other alu_ext[2:1] code behaves like 00.
    if (alu_ext_i == EXT_LUI) begin
      result_o = op2_i;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: computes on issue and holds results in a small FIFO until the CDB grants.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [DATA_W-1:0] issue_op1_data,
  input  logic [DATA_W-1:0] issue_op2_data,
  input  logic [TAG_W-1:0]  issue_rd_tag,
  input  logic [F3_W-1:0]   issue_funct3,
  input  logic [EXT_W-1:0]  issue_alu_ext,
  output logic              issue_ready,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag_out,
  output logic [DATA_W-1:0] cdb_data_out
);

  localparam int unsigned OCC_W = $clog2(RES_DEPTH + 1);
  localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  res_entry_t       mem_q [RES_DEPTH];
  res_entry_t       wr_entry;
  res_entry_t       head;
  logic [DATA_W-1:0] alu_result;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  alu_core u_alu_core (
    .op1_i     (issue_op1_data),
    .op2_i     (issue_op2_data),
    .funct3_i  (issue_funct3),
    .alu_ext_i (issue_alu_ext),
    .result_o  (alu_result)
  );

  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign issue_ready = (occ_q < OCC_W'(RES_DEPTH));
  assign cdb_req     = (occ_q != '0);
  assign push        = issue_valid && issue_ready;
  assign pop         = cdb_req && cdb_grant;

  assign wr_entry.tag  = issue_rd_tag;
  assign wr_entry.data = alu_result;
  assign head          = mem_q[rd_ptr_q];

  assign cdb_tag_out  = cdb_req ? head.tag  : '0;
  assign cdb_data_out = cdb_req ? head.data : '0;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage is not reset; empty-buffer outputs are masked above.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule
